// File: rtl/cpu_dma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_dma_ctrl : NUM_CH prioritised DMA channels that stall the 6502  |
// | Optional abort input/aborted pulses under macro CPU_DMA_ABORT_EN.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cpu_dma_ctrl #(
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*16-1:0]    src,
  input  logic [NUM_CH*LEN_W-1:0] len,
  input  logic [NUM_CH*16-1:0]    dst,
  input  logic [NUM_CH-1:0]       dst_inc,
  input  logic                    cpu_rw,
  output logic                    cpu_ready,
  output logic                    bus_own,
  output logic [15:0]             bus_addr,
  output logic                    bus_rw,
  output logic [7:0]              bus_wdata,
  input  logic [7:0]              bus_rdata,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [CH_W-1:0]         active_ch
`ifdef CPU_DMA_ABORT_EN
  ,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [15:0]       src_q [NUM_CH];
  logic [15:0]       src_d [NUM_CH];
  logic [15:0]       dst_q [NUM_CH];
  logic [15:0]       dst_d [NUM_CH];
  logic [LEN_W-1:0]  len_q [NUM_CH];
  logic [LEN_W-1:0]  len_d [NUM_CH];
  logic [NUM_CH-1:0] inc_q, inc_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              bus_own_q, bus_own_d;
  logic              bus_rw_q, bus_rw_d;
  logic [15:0]       bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] remain;
  logic [LEN_W-1:0]  idx_inc;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              end_xfer;
`ifdef CPU_DMA_ABORT_EN
  logic              abort_q, abort_d;
  logic [NUM_CH-1:0] aborted_q, aborted_d;
`endif

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] p);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (p[i]) lowest = CH_W'(i);
    end
  endfunction

  always_comb begin
    accept    = req & ~pending_q;
    pending_d = pending_q | accept;
    for (int i = 0; i < NUM_CH; i++) begin
      src_d[i] = accept[i] ? src[16*i +: 16]       : src_q[i];
      dst_d[i] = accept[i] ? dst[16*i +: 16]       : dst_q[i];
      len_d[i] = accept[i] ? len[LEN_W*i +: LEN_W] : len_q[i];
    end
    inc_d       = (dst_inc & accept) | (inc_q & ~accept);
    phase_d     = ~phase_q;
    state_d     = state_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    done_d      = '0;
    idx_inc     = idx_q + LEN_W'(1);
    remain      = pending_q & ~(NUM_CH'(1) << ch_q);
    first_ch    = lowest(pending_q);
    next_ch     = lowest(remain);
    // len of zero wraps idx_inc back to zero after 2^LEN_W bytes
    end_xfer    = (idx_inc == len_q[ch_q]);
`ifdef CPU_DMA_ABORT_EN
    abort_d     = abort_q;
    aborted_d   = '0;
    end_xfer    = end_xfer | abort_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|pending_d) state_d = S_HALT;
      end
      S_HALT: begin
        if (cpu_rw) begin
          ch_d       = first_ch;
          idx_d      = '0;
          bus_addr_d = src_q[first_ch];
          state_d    = phase_q ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: begin
        bus_addr_d = src_q[ch_q];
        state_d    = S_READ;
      end
      S_READ: begin
        bus_wdata_d = bus_rdata;
        bus_addr_d  = inc_q[ch_q] ? dst_q[ch_q] + 16'(idx_q) : dst_q[ch_q];
        state_d     = S_WRITE;
`ifdef CPU_DMA_ABORT_EN
        abort_d     = abort;
`endif
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (end_xfer) begin
          pending_d[ch_q] = 1'b0;
`ifdef CPU_DMA_ABORT_EN
          abort_d = 1'b0;
          if (abort_q) aborted_d[ch_q] = 1'b1;
          else         done_d[ch_q]    = 1'b1;
`else
          done_d[ch_q] = 1'b1;
`endif
          // WRITE sits on an odd phase, so the next channel can read at once
          if (|remain) begin
            ch_d       = next_ch;
            idx_d      = '0;
            bus_addr_d = src_q[next_ch];
            state_d    = S_READ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bus_addr_d = src_q[ch_q] + 16'(idx_inc);
          state_d    = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_ready_d = (state_d == S_IDLE);
    bus_own_d   = (state_d == S_ALIGN) || (state_d == S_READ) || (state_d == S_WRITE);
    bus_rw_d    = (state_d != S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      pending_q   <= '0;
      done_q      <= '0;
      inc_q       <= '0;
      idx_q       <= '0;
      ch_q        <= '0;
      cpu_ready_q <= 1'b1;
      bus_own_q   <= 1'b0;
      bus_rw_q    <= 1'b1;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
`ifdef CPU_DMA_ABORT_EN
      abort_q     <= 1'b0;
      aborted_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      inc_q       <= inc_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      cpu_ready_q <= cpu_ready_d;
      bus_own_q   <= bus_own_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= src_d[i];
        dst_q[i] <= dst_d[i];
        len_q[i] <= len_d[i];
      end
`ifdef CPU_DMA_ABORT_EN
      abort_q     <= abort_d;
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign bus_own   = bus_own_q;
  assign bus_addr  = bus_addr_q;
  assign bus_rw    = bus_rw_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = pending_q;
  assign done      = done_q;
  assign active_ch = ch_q;
`ifdef CPU_DMA_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_dma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_dma_ctrl : scoreboard bench for cpu_dma_ctrl (default build) |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cpu_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] src;
  logic [15:0] len;
  logic [31:0] dst;
  logic [1:0]  dst_inc;
  logic        cpu_rw;
  logic        cpu_ready;
  logic        bus_own;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [0:0]  active_ch;

  typedef struct packed {
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t       sb[$];
  xfer_t       sb_exp;
  int          checks   = 0;
  int          failures = 0;
  int          nwrites  = 0;
  logic        tb_phase;
  logic [15:0] prev_addr = '0;

  cpu_dma_ctrl #(.NUM_CH(2), .LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .src       (src),
    .len       (len),
    .dst       (dst),
    .dst_inc   (dst_inc),
    .cpu_rw    (cpu_rw),
    .cpu_ready (cpu_ready),
    .bus_own   (bus_own),
    .bus_addr  (bus_addr),
    .bus_rw    (bus_rw),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .busy      (busy),
    .done      (done),
    .active_ch (active_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign bus_rdata = mem_byte(bus_addr);

  // Free-running phase reference: 0 in the first cycle after reset
  always @(posedge clk) tb_phase <= reset ? 1'b0 : ~tb_phase;

  // Every DMA write must match the oldest expected byte, including the read before it
  always @(negedge clk) begin
    if (!reset && bus_own && !bus_rw) begin
      checks++;
      nwrites++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write addr=%h data=%h", bus_addr, bus_wdata);
      end else begin
        sb_exp = sb.pop_front();
        if (prev_addr !== sb_exp.raddr || bus_addr !== sb_exp.waddr || bus_wdata !== sb_exp.data) begin
          failures++;
          $display("FAIL sb_byte got rd=%h wr=%h data=%h want rd=%h wr=%h data=%h",
                   prev_addr, bus_addr, bus_wdata, sb_exp.raddr, sb_exp.waddr, sb_exp.data);
        end
      end
    end
    prev_addr = bus_addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic set_ch(input int ch, input logic [15:0] s, input logic [7:0] l,
                        input logic [15:0] d, input logic inc);
    src[16*ch +: 16] = s;
    len[8*ch +: 8]   = l;
    dst[16*ch +: 16] = d;
    dst_inc[ch]      = inc;
  endtask

  task automatic push_xfer(input logic [15:0] s, input int n, input logic [15:0] d, input logic inc);
    for (int k = 0; k < n; k++) begin
      xfer_t e;
      e.raddr = s + 16'(k);
      e.waddr = inc ? d + 16'(k) : d;
      e.data  = mem_byte(e.raddr);
      sb.push_back(e);
    end
  endtask

  task automatic wait_phase(input logic p);
    if (tb_phase !== p) @(negedge clk);
  endtask

  task automatic start(input logic [1:0] r, output logic p0);
    p0  = tb_phase;
    req = r;
    @(negedge clk);
    req = 2'b00;
  endtask

  task automatic measure(input int rw_low, output int stall, output int halt,
                         output int d0n, output int d1n, output int d0_at,
                         output int d1_at, output bit fin);
    stall = 0; halt = 0; d0n = 0; d1n = 0; d0_at = -1; d1_at = -1; fin = 1'b0;
    for (int t = 0; t < 1200 && !fin; t++) begin
      if (done[0]) begin d0n++; if (d0_at < 0) d0_at = t; end
      if (done[1]) begin d1n++; if (d1_at < 0) d1_at = t; end
      if (!cpu_ready) begin
        stall++;
        if (!bus_own) halt++;
      end else if (stall > 0) begin
        fin = 1'b1;
      end
      if (!fin) begin
        cpu_rw = ((t + 1) > rw_low);
        @(negedge clk);
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (done[0]) d0n++;
      if (done[1]) d1n++;
    end
    cpu_rw = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; src = '0; len = '0; dst = '0; dst_inc = '0; cpu_rw = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_cpu_ready got=%b want=1", cpu_ready); end
    checks++; if (bus_own !== 1'b0) begin failures++; $display("FAIL rst_bus_own got=%b want=0", bus_own); end
    checks++; if (bus_rw !== 1'b1) begin failures++; $display("FAIL rst_bus_rw got=%b want=1", bus_rw); end
    checks++; if (bus_addr !== 16'h0000) begin failures++; $display("FAIL rst_bus_addr got=%h want=0000", bus_addr); end
    checks++; if (bus_wdata !== 8'h00) begin failures++; $display("FAIL rst_bus_wdata got=%h want=00", bus_wdata); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL rst_busy got=%b want=00", busy); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL rst_done got=%b want=00", done); end
    checks++; if (active_ch !== 1'b0) begin failures++; $display("FAIL rst_active_ch got=%b want=0", active_ch); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || bus_own !== 1'b0) begin
      failures++; $display("FAIL idle_after_rst got ready=%b own=%b want ready=1 own=0", cpu_ready, bus_own);
    end
  endtask

  task automatic test_oam(input logic ph, input int want_stall);
    int stall, halt, d0n, d1n, d0_at, d1_at; bit fin; logic p0;
    set_ch(0, 16'h0200, 8'd0, 16'h2004, 1'b0);
    push_xfer(16'h0200, 256, 16'h2004, 1'b0);
    wait_phase(ph);
    start(2'b01, p0);
    checks++; if (busy !== 2'b01) begin failures++; $display("FAIL oam_busy got=%b want=01", busy); end
    measure(0, stall, halt, d0n, d1n, d0_at, d1_at, fin);
    checks++; if (!fin) begin failures++; $display("FAIL oam_timeout got=unfinished want=finished"); end
    checks++; if (stall !== want_stall) begin failures++; $display("FAIL oam_stall ph=%b got=%0d want=%0d", p0, stall, want_stall); end
    checks++; if (halt !== 1) begin failures++; $display("FAIL oam_halt got=%0d want=1", halt); end
    checks++; if (d0n !== 1 || d0_at !== want_stall) begin
      failures++; $display("FAIL oam_done0 got n=%0d at=%0d want n=1 at=%0d", d0n, d0_at, want_stall);
    end
    checks++; if (d1n !== 0) begin failures++; $display("FAIL oam_done1 got=%0d want=0", d1n); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL oam_left got=%0d want=0", sb.size()); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL oam_busy_end got=%b want=00", busy); end
  endtask

  task automatic test_halt_on_write;
    int stall, halt, d0n, d1n, d0_at, d1_at, want; bit fin; logic p0;
    set_ch(0, 16'h0300, 8'd4, 16'h4000, 1'b1);
    push_xfer(16'h0300, 4, 16'h4000, 1'b1);
    start(2'b01, p0);
    measure(3, stall, halt, d0n, d1n, d0_at, d1_at, fin);
    want = 4 + int'(p0 ^ 1'b1) + 8;
    checks++; if (halt !== 4) begin failures++; $display("FAIL halt_len got=%0d want=4", halt); end
    checks++; if (stall !== want) begin failures++; $display("FAIL halt_stall got=%0d want=%0d", stall, want); end
    checks++; if (d0n !== 1) begin failures++; $display("FAIL halt_done0 got=%0d want=1", d0n); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL halt_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    int stall, halt, d0n, d1n, d0_at, d1_at, a; bit fin; logic p0;
    set_ch(0, 16'h0400, 8'd2, 16'h5000, 1'b1);
    set_ch(1, 16'h0500, 8'd3, 16'h6000, 1'b0);
    push_xfer(16'h0400, 2, 16'h5000, 1'b1);
    push_xfer(16'h0500, 3, 16'h6000, 1'b0);
    start(2'b11, p0);
    checks++; if (busy !== 2'b11) begin failures++; $display("FAIL b2b_busy got=%b want=11", busy); end
    measure(0, stall, halt, d0n, d1n, d0_at, d1_at, fin);
    a = int'(p0);
    checks++; if (stall !== 1 + a + 10) begin failures++; $display("FAIL b2b_stall got=%0d want=%0d", stall, 1 + a + 10); end
    checks++; if (d0n !== 1 || d0_at !== 1 + a + 4) begin
      failures++; $display("FAIL b2b_done0 got n=%0d at=%0d want n=1 at=%0d", d0n, d0_at, 1 + a + 4);
    end
    checks++; if (d1n !== 1 || d1_at !== 1 + a + 10) begin
      failures++; $display("FAIL b2b_done1 got n=%0d at=%0d want n=1 at=%0d", d1n, d1_at, 1 + a + 10);
    end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL b2b_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_wraparound;
    int stall, halt, d0n, d1n, d0_at, d1_at, want; bit fin; logic p0;
    set_ch(1, 16'hFFFE, 8'd4, 16'h1000, 1'b1);
    push_xfer(16'hFFFE, 4, 16'h1000, 1'b1);
    start(2'b10, p0);
    measure(0, stall, halt, d0n, d1n, d0_at, d1_at, fin);
    want = 1 + int'(p0) + 8;
    checks++; if (stall !== want) begin failures++; $display("FAIL wrap_stall got=%0d want=%0d", stall, want); end
    checks++; if (d1n !== 1 || d0n !== 0) begin failures++; $display("FAIL wrap_done got d0=%0d d1=%0d want d0=0 d1=1", d0n, d1n); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL wrap_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_mid;
    int stall, halt, d0n, d1n, d0_at, d1_at, base, t, dn; bit fin; logic p0;
    set_ch(0, 16'h0200, 8'd0, 16'h2004, 1'b0);
    push_xfer(16'h0200, 256, 16'h2004, 1'b0);
    base = nwrites;
    start(2'b01, p0);
    t = 0;
    while (nwrites < base + 10 && t < 200) begin @(negedge clk); t++; end
    checks++; if (t >= 200) begin failures++; $display("FAIL rmid_timeout got=%0d want=10 writes", nwrites - base); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || bus_own !== 1'b0 || busy !== 2'b00 || done !== 2'b00) begin
      failures++; $display("FAIL rmid_state got ready=%b own=%b busy=%b done=%b want 1 0 00 00", cpu_ready, bus_own, busy, done);
    end
    sb.delete();
    reset = 1'b0;
    dn = 0;
    repeat (3) begin @(negedge clk); if (done !== 2'b00 || !cpu_ready) dn++; end
    checks++; if (dn !== 0) begin failures++; $display("FAIL rmid_quiet got=%0d want=0", dn); end
    set_ch(1, 16'h0700, 8'd5, 16'h2004, 1'b0);
    push_xfer(16'h0700, 5, 16'h2004, 1'b0);
    wait_phase(1'b0);
    start(2'b10, p0);
    measure(0, stall, halt, d0n, d1n, d0_at, d1_at, fin);
    checks++; if (stall !== 11) begin failures++; $display("FAIL rmid_new_stall got=%0d want=11", stall); end
    checks++; if (d1n !== 1 || d0n !== 0) begin failures++; $display("FAIL rmid_new_done got d0=%0d d1=%0d want d0=0 d1=1", d0n, d1n); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL rmid_left got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_oam(1'b0, 513);
    test_oam(1'b1, 514);
    test_halt_on_write();
    test_back_to_back();
    test_wraparound();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
